dm_responder: RTL and testbench
===============================

Name: dm_responder

Overview:
Data-memory responder on the far end of the CPU data-memory port (mem_w / address / store data / DMType / load data). It holds a word-organised RAM and performs sub-word stores with byte lanes. Loads take two cycles and are sign- or zero-extended. Every accepted request gets a single-beat response over a valid/ready handshake, so the pipelined core can stall its MEM stage on it.

Parameters:
ADDR_W, 10, word-index width; depth = 2**ADDR_W words (4 KiB by default)

Ports:
clk  input  1  clock, all state updates on the rising edge
rst  input  1  reset, asynchronous, active-low
req_valid  input  1  CPU presents a request this cycle
req_ready  output  1  responder can accept a request this cycle
mem_w  input  1  1 = store, 0 = load
addr  input  32  byte address from the ALU
wdata  input  32  store data; the low byte or half is used for sub-word stores
DMType  input  3  000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned
rsp_valid  output  1  one-cycle response pulse
rdata  output  32  extended load data; 0 for stores and for errors
misalign_err  output  1  qualifies rsp_valid; the access was misaligned and was not performed

Behaviour:
- Reset (rst=0, asynchronous): state goes to IDLE (or CLEAR, see below). req_ready=0 while reset is asserted. rsp_valid=0, rdata=0, misalign_err=0. RAM contents are not reset.
- Accept: a request is accepted on an edge where req_valid & req_ready. req_ready is 1 only in IDLE. The request fields are sampled only at acceptance.
- Word index is addr[ADDR_W+1:2]. Upper address bits are ignored, so accesses wrap modulo depth.
- DMType values 101, 110 and 111 are treated as word.
- Misaligned access:
  - Defined as a word access with addr[1:0] != 0, or a half access with addr[0] = 1.
  - The RAM is not read or written.
  - The FSM goes to RESP. The response carries misalign_err=1 and rdata=0.
- Store, aligned:
  - The byte lanes are written at the accept edge. Word writes all 4 lanes. Half writes lanes {addr[1],0}+1 and {addr[1],0}, using wdata[15:0]. Byte writes lane addr[1:0], using wdata[7:0].
  - Unselected lanes are unchanged.
  - The FSM goes to RESP. The response carries rdata=0 and misalign_err=0.
  - Store-to-response latency is 1 cycle.
- Load, aligned:
  - The accept edge moves the FSM to LOAD and latches the index, offset and type.
  - The RAM is read synchronously in LOAD.
  - The FSM then goes to RESP with rdata set to the extracted and extended value. Byte uses offset addr[1:0], half uses addr[1]; signed types sign-extend, unsigned types zero-extend.
  - Load latency is 2 cycles from accept to rsp_valid.
- FSM:
  - IDLE -> RESP on an accepted store or a misaligned request.
  - IDLE -> LOAD on an accepted aligned load.
  - LOAD -> RESP unconditionally.
  - RESP -> IDLE unconditionally.
  - rsp_valid=1 only in RESP. rdata and misalign_err are held in RESP and return to 0 in IDLE.
- Responses cannot be back-pressured; the CPU always takes the response beat.
- Minimum request spacing: 2 cycles for stores and errors, 3 cycles for loads.
- A load issued after a store to the same word returns the stored data. There is no forwarding hazard, because the store completes at its accept edge.
- Reset asserted mid-transaction: the in-flight response is dropped and no rsp_valid is produced. A store already written at its accept edge stays written.

Optional Feature:
DM_CLEAR_EN
- Defined: when rst is released, the FSM enters CLEAR and writes 0 to word 0 through word depth-1, one word per cycle. req_ready stays 0 during CLEAR, then the FSM goes to IDLE. req_ready first rises 2**ADDR_W cycles after rst deasserts. Asserting reset during CLEAR restarts the clear from word 0.
- Undefined: the FSM enters IDLE directly after reset, req_ready=1 on the first edge after release, and RAM contents are whatever was preloaded or left over.

Test Plan:
- Word store then load: store addr 0x10 with wdata 0xDEADBEEF and DMType 000, then load addr 0x10 DMType 000 -> store rsp 1 cycle after accept with rdata 0; load rsp 2 cycles after accept with rdata 0xDEADBEEF and misalign_err 0.
- Byte lanes: store byte 0x80 to addr 0x21 over an existing 0x11223344 -> word reads 0x11228044. Then load addr 0x21 as byte signed -> 0xFFFFFF80; as byte unsigned -> 0x00000080.
- Half extension: store half 0x8001 at addr 0x32 -> word reads 0x8001xxxx with the low half unchanged. Load half signed at 0x32 -> 0xFFFF8001; half unsigned -> 0x00008001.
- Misalign: word load at 0x13 and half store at 0x41 -> rsp 1 cycle after accept with misalign_err=1 and rdata=0; a follow-up read shows memory at 0x40 unchanged.
- Handshake and wrap: req_valid held high for back-to-back loads -> req_ready low in LOAD and RESP, so the second request is accepted exactly 3 cycles after the first. With ADDR_W=10, a store to 0x1000 followed by a load from 0x0 returns the stored data.
- Reset mid-load: assert rst in LOAD -> no rsp_valid, all outputs 0, FSM restarts cleanly. With DM_CLEAR_EN: req_ready=0 for 1024 cycles after release, then any load returns 0.

Source files
------------

// File: rtl/dm_responder.sv
// dm_responder: data-memory responder for the CPU MEM stage.
// Word-organised RAM with byte-lane stores and sign/zero-extended loads.
// Every accepted request gets exactly one response beat.
// Optional build macro: DM_CLEAR_EN (zero the whole RAM after reset release).
//
// Handshake: a request is taken on a rising edge where req_valid && req_ready;
// req_ready is high only in IDLE (and never while rst is low). rsp_valid is a
// one-cycle pulse in RESP that the CPU must always accept (no back-pressure).
module dm_responder #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_w,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  DMType,
  output logic        rsp_valid,
  output logic [31:0] rdata,
  output logic        misalign_err,
  output logic [1:0]  dbg_state
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_RESP  = 2'd2,
    S_CLEAR = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [31:0]       mem_q [DEPTH];
  logic [31:0]       raw_q;
  logic [ADDR_W-1:0] idx_q;
  logic [1:0]        off_q;
  logic              half_q, byte_q, signed_q, is_load_q, err_q;

  logic              is_half, is_byte, is_signed, misalign, accept;
  logic              wr_en;
  logic [3:0]        wr_be;
  logic [ADDR_W-1:0] wr_idx, req_idx;
  logic [31:0]       wr_data;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;

  // Upper address bits are ignored so that accesses wrap modulo the depth.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_W+2];

`ifdef DM_CLEAR_EN
  logic [ADDR_W-1:0] clr_q, clr_d;
`endif

  // Decode the incoming request; reserved DMType codes fall back to word.
  always_comb begin
    is_half   = (DMType == 3'b001) || (DMType == 3'b010);
    is_byte   = (DMType == 3'b011) || (DMType == 3'b100);
    is_signed = (DMType == 3'b001) || (DMType == 3'b011);
    misalign  = (!is_half && !is_byte && (addr[1:0] != 2'b00)) ||
                (is_half && addr[0]);
    req_idx   = addr[ADDR_W+1:2];
    accept    = req_valid && req_ready;
  end

  // Next-state logic plus the RAM write port (stores commit at the accept edge).
  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    wr_be   = 4'b0000;
    wr_idx  = req_idx;
    wr_data = 32'h0;
`ifdef DM_CLEAR_EN
    clr_d   = clr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (misalign) begin
            state_d = S_RESP;
          end else if (mem_w) begin
            wr_en   = 1'b1;
            state_d = S_RESP;
            if (is_byte) begin
              wr_be   = 4'b0001 << addr[1:0];
              wr_data = {4{wdata[7:0]}};
            end else if (is_half) begin
              wr_be   = addr[1] ? 4'b1100 : 4'b0011;
              wr_data = {2{wdata[15:0]}};
            end else begin
              wr_be   = 4'b1111;
              wr_data = wdata;
            end
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD:  state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      S_CLEAR: begin
`ifdef DM_CLEAR_EN
        wr_en   = 1'b1;
        wr_be   = 4'b1111;
        wr_idx  = clr_q;
        wr_data = 32'h0;
        clr_d   = clr_q + ADDR_W'(1);
        if (clr_q == {ADDR_W{1'b1}}) state_d = S_IDLE;
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset restarts the clear sweep when it is enabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
`ifdef DM_CLEAR_EN
      state_q <= S_CLEAR;
      clr_q   <= '0;
`else
      state_q <= S_IDLE;
`endif
    end else begin
      state_q <= state_d;
`ifdef DM_CLEAR_EN
      clr_q   <= clr_d;
`endif
    end
  end

  // Latch request fields at acceptance only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q     <= '0;
      off_q     <= 2'b00;
      half_q    <= 1'b0;
      byte_q    <= 1'b0;
      signed_q  <= 1'b0;
      is_load_q <= 1'b0;
      err_q     <= 1'b0;
    end else if (accept) begin
      idx_q     <= req_idx;
      off_q     <= addr[1:0];
      half_q    <= is_half;
      byte_q    <= is_byte;
      signed_q  <= is_signed;
      is_load_q <= !mem_w && !misalign;
      err_q     <= misalign;
    end
  end

  // RAM array: byte-lane writes and a synchronous read in LOAD; never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem_q[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
    if (state_q == S_LOAD) raw_q <= mem_q[idx_q];
  end

  // Response outputs: lane extraction/extension, forced to zero outside RESP.
  always_comb begin
    byte_v       = raw_q[{off_q, 3'b000} +: 8];
    half_v       = off_q[1] ? raw_q[31:16] : raw_q[15:0];
    rsp_valid    = (state_q == S_RESP);
    misalign_err = rsp_valid && err_q;
    rdata        = 32'h0;
    if (rsp_valid && is_load_q) begin
      if (byte_q)      rdata = signed_q ? {{24{byte_v[7]}}, byte_v} : {24'h0, byte_v};
      else if (half_q) rdata = signed_q ? {{16{half_v[15]}}, half_v} : {16'h0, half_v};
      else             rdata = raw_q;
    end
    req_ready = rst && (state_q == S_IDLE);
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: directed scoreboard bench for dm_responder (ADDR_W=10).
module tb_dm_responder;

  logic        clk, rst, req_valid, mem_w;
  logic [31:0] addr, wdata;
  logic [2:0]  DMType;
  logic        req_ready, rsp_valid, misalign_err;
  logic [31:0] rdata;
  logic [1:0]  dbg_state;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int n;
  logic [32:0] exp_q[$];
  logic [32:0] mon_e;
  int          acc_q[$];

`ifdef DM_CLEAR_EN
  localparam int CLEAR_CYC = 1024;
  localparam logic [1:0] RST_STATE = 2'd3;
  localparam logic [31:0] AFTER_RST_10 = 32'h0;
`else
  localparam int CLEAR_CYC = 0;
  localparam logic [1:0] RST_STATE = 2'd0;
  localparam logic [31:0] AFTER_RST_10 = 32'hDEADBEEF;
`endif

  dm_responder #(.ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .mem_w(mem_w), .addr(addr), .wdata(wdata), .DMType(DMType),
    .rsp_valid(rsp_valid), .rdata(rdata), .misalign_err(misalign_err),
    .dbg_state(dbg_state)
  );

  // Clock and cycle counter / acceptance log.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (rst && req_valid && req_ready) acc_q.push_back(cyc);
    cyc = cyc + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every response beat pops one expected {misalign_err, rdata}.
  always @(negedge clk) begin
    if (rst && rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp", {misalign_err, rdata}, mon_e);
      end
    end
  end

  task automatic wait_ready(input string tag, input int exp_cycles);
    int k;
    k = 0;
    while (!req_ready && k < 5000) begin
      @(posedge clk); #1; k++;
    end
    check(tag, k, exp_cycles);
  endtask

  // Driver: one request, push expectation, check accept-to-response latency.
  task automatic send(input string tag, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [2:0] t, input logic e,
                      input logic [31:0] exp_r, input int exp_lat);
    int k;
    k = 0;
    while (!req_ready && k < 20) begin
      @(posedge clk); #1; k++;
    end
    req_valid = 1'b1; mem_w = w; addr = a; wdata = d; DMType = t;
    exp_q.push_back({e, exp_r});
    @(posedge clk); #1;
    req_valid = 1'b0;
    mem_w  = 1'($urandom_range(0, 1));
    addr   = $urandom;
    wdata  = $urandom;
    DMType = 3'($urandom_range(0, 7));
    k = 0;
    do begin
      @(negedge clk); k++;
    end while (!rsp_valid && k < 6);
    check({tag, "_lat"}, k, exp_lat);
    #1;
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; mem_w = 1'b0; addr = 32'h0; wdata = 32'h0; DMType = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_misalign", misalign_err, 0);
    check("rst_state", dbg_state, RST_STATE);
    @(negedge clk); rst = 1'b1; #1;
    wait_ready("ready_after_release", CLEAR_CYC);

    // Word store then load.
    send("st_w10", 1, 32'h10, 32'hDEADBEEF, 3'b000, 0, 32'h0, 1);
    send("ld_w10", 0, 32'h10, 32'h0, 3'b000, 0, 32'hDEADBEEF, 2);

    // Byte lanes.
    send("st_w20", 1, 32'h20, 32'h11223344, 3'b000, 0, 32'h0, 1);
    send("st_b21", 1, 32'h21, 32'hAAAAAA80, 3'b011, 0, 32'h0, 1);
    send("ld_w20", 0, 32'h20, 32'h0, 3'b000, 0, 32'h11228044, 2);
    send("ld_bs21", 0, 32'h21, 32'h0, 3'b011, 0, 32'hFFFFFF80, 2);
    send("ld_bu21", 0, 32'h21, 32'h0, 3'b100, 0, 32'h00000080, 2);

    // Half extension.
    send("st_w30", 1, 32'h30, 32'h55667788, 3'b000, 0, 32'h0, 1);
    send("st_h32", 1, 32'h32, 32'h12348001, 3'b001, 0, 32'h0, 1);
    send("ld_w30", 0, 32'h30, 32'h0, 3'b000, 0, 32'h80017788, 2);
    send("ld_hs32", 0, 32'h32, 32'h0, 3'b001, 0, 32'hFFFF8001, 2);
    send("ld_hu32", 0, 32'h32, 32'h0, 3'b010, 0, 32'h00008001, 2);
    send("ld_hs30", 0, 32'h30, 32'h0, 3'b001, 0, 32'h00007788, 2);

    // Misaligned accesses leave memory untouched.
    send("st_w40", 1, 32'h40, 32'hCAFEF00D, 3'b000, 0, 32'h0, 1);
    send("mis_ld13", 0, 32'h13, 32'h0, 3'b000, 1, 32'h0, 1);
    send("mis_st41", 1, 32'h41, 32'hFFFFFFFF, 3'b001, 1, 32'h0, 1);
    send("ld_w40", 0, 32'h40, 32'h0, 3'b000, 0, 32'hCAFEF00D, 2);
    send("ld_t7_40", 0, 32'h40, 32'h0, 3'b111, 0, 32'hCAFEF00D, 2);

    // Address wrap.
    send("st_w1000", 1, 32'h1000, 32'h0BADC0DE, 3'b000, 0, 32'h0, 1);
    send("ld_w0", 0, 32'h0, 32'h0, 3'b000, 0, 32'h0BADC0DE, 2);
    send("ld_bu3", 0, 32'h3, 32'h0, 3'b100, 0, 32'h0000000B, 2);

    // Back-to-back loads with req_valid held high.
    acc_q.delete();
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    req_valid = 1'b1; mem_w = 1'b0; addr = 32'h10; DMType = 3'b000;
    exp_q.push_back({1'b0, 32'hDEADBEEF});
    @(posedge clk); #1;
    check("b2b_ready_in_load", req_ready, 0);
    addr = 32'h0;
    exp_q.push_back({1'b0, 32'h0BADC0DE});
    n = 0;
    while (acc_q.size() < 2 && n < 10) begin @(posedge clk); #1; n++; end
    req_valid = 1'b0;
    check("b2b_accepts", acc_q.size(), 2);
    if (acc_q.size() == 2) check("b2b_gap", acc_q[1] - acc_q[0], 3);
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin @(negedge clk); #1; n++; end
    check("b2b_drain", exp_q.size(), 0);

    // Reset asserted while a load is in flight: response is dropped.
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    req_valid = 1'b1; mem_w = 1'b0; addr = 32'h40; DMType = 3'b000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("midrst_in_load", dbg_state, 2'd1);
    rst = 1'b0; #1;
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_rdata", rdata, 0);
    check("midrst_misalign", misalign_err, 0);
    check("midrst_ready", req_ready, 0);
    check("midrst_state", dbg_state, RST_STATE);
    repeat (4) @(posedge clk);
    @(negedge clk); rst = 1'b1; #1;
    wait_ready("ready_after_midrst", CLEAR_CYC);
    send("ld_after_rst", 0, 32'h10, 32'h0, 3'b000, 0, AFTER_RST_10, 2);
    send("ld_after_rst_w40", 0, 32'h40, 32'h0, 3'b000, 0,
         (CLEAR_CYC != 0) ? 32'h0 : 32'hCAFEF00D, 2);

    repeat (3) @(posedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
